// File: rtl/trig_lut_pipe_if.sv
// trig_lut_pipe_if: request/result stream bundle for trig_lut_pipe.
//   in_valid/in_ready/in_angle/in_tag      : request channel (master drives valid/angle/tag)
//   out_valid/out_ready/out_sin/out_cos/out_tag : result channel (master drives out_ready)
// Both channels use valid/ready: a transfer happens on the clock edge where
// valid && ready are both high; the sender holds its payload until then.
// Parameters must match the trig_lut_pipe instance this bundle connects to.
interface trig_lut_pipe_if #(
  parameter int ANGLE_W = 9,
  parameter int TAG_W   = 4,
  parameter int OUT_W   = 18
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ANGLE_W-1:0]      in_angle;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_sin;
  logic signed [OUT_W-1:0] out_cos;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_angle, in_tag, out_ready,
    input  in_ready, out_valid, out_sin, out_cos, out_tag
  );

  modport slave (
    input  in_valid, in_angle, in_tag, out_ready,
    output in_ready, out_valid, out_sin, out_cos, out_tag
  );
endinterface

// File: rtl/trig_lut_pipe.sv
// trig_lut_pipe: three-stage pipelined sin/cos of an integer-degree angle.
//   Clk   : system clock
//   Reset : synchronous, active-high; clears all stage valids and the outputs
//   bus   : trig_lut_pipe_if.slave
//           request  in_valid/in_ready/in_angle/in_tag
//           result   out_valid/out_ready/out_sin/out_cos/out_tag
// Outputs are signed value * 2**FRAC_W, taken from a 91-entry quarter-wave
// table T[i] = round(65536*sin(i deg)) with quadrant folding.
//
// Handshake: the pipe moves as one unit. adv = !out_valid || out_ready.
// in_ready = adv, so a request is taken on any edge where the output register
// is empty or being consumed. When adv=0 every register holds, which keeps the
// results stable and in acceptance order; bubbles are not squeezed out.
module trig_lut_pipe #(
  parameter int ANGLE_W = 9,
  parameter int FRAC_W  = 16,
  parameter int OUT_W   = 18,
  parameter int TAG_W   = 4
) (
  input logic           Clk,
  input logic           Reset,
  trig_lut_pipe_if.slave bus
);

  // pi * 2**60 (hex digits of pi), used only to build the table at elaboration.
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // Taylor series in Q60 fixed point; error is far below the rounding step.
  function automatic logic [16:0] sin_q16(input int deg);
    logic [127:0] x, x2, term, sum;
    x    = (128'(deg) * PI_Q60) / 128'd180;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * x2) >> 60) / 128'(2 * k * (2 * k + 1));
      if (k[0]) sum = sum - term;
      else      sum = sum + term;
    end
    sum = (sum * 128'd65536 + (128'd1 << 59)) >> 60;
    return sum[16:0];
  endfunction

  logic [16:0] tbl [0:90];
  for (genvar g = 0; g <= 90; g++) begin : g_tbl
    localparam logic [16:0] TVAL = sin_q16(g);
    assign tbl[g] = TVAL;
  end

  // Round half up into FRAC_W bits; the sum never exceeds 17 bits.
  localparam int SH  = 16 - FRAC_W;
  localparam int RND = (FRAC_W >= 16) ? 0 : (1 << (15 - FRAC_W));

  function automatic logic [OUT_W-1:0] signed_out(input logic [16:0] mag,
                                                  input logic neg);
    logic [16:0]      scaled;
    logic [OUT_W-1:0] v;
    scaled = (mag + 17'(RND)) >> SH;
    v      = OUT_W'(scaled);
    return neg ? -v : v;
  endfunction

  logic adv;

  // stage 1: reduced angle folded into table indices and signs
  logic             s1_valid;
  logic [6:0]       s1_sidx, s1_cidx;
  logic             s1_sneg, s1_cneg;
  logic [TAG_W-1:0] s1_tag;

  // stage 2: table magnitudes
  logic             s2_valid;
  logic [16:0]      s2_smag, s2_cmag;
  logic             s2_sneg, s2_cneg;
  logic [TAG_W-1:0] s2_tag;

  // stage 3: output register
  logic                    o_valid;
  logic signed [OUT_W-1:0] o_sin, o_cos;
  logic [TAG_W-1:0]        o_tag;

  logic [9:0] a_ext, r;
  logic [6:0] sidx_d, cidx_d;
  logic       sneg_d, cneg_d;

  // Indices are always 0..90, so the low 7 bits of each 10-bit difference
  // are exact.
  always_comb begin
    a_ext = 10'(bus.in_angle);
    if (a_ext >= 10'd720)      r = a_ext - 10'd720;
    else if (a_ext >= 10'd360) r = a_ext - 10'd360;
    else                       r = a_ext;
    sidx_d = 7'(r);
    cidx_d = 7'(10'd90 - r);
    sneg_d = 1'b0;
    cneg_d = 1'b0;
    if (r <= 10'd90) begin
      sidx_d = 7'(r);
      cidx_d = 7'(10'd90 - r);
    end else if (r <= 10'd180) begin
      sidx_d = 7'(10'd180 - r);
      cidx_d = 7'(r - 10'd90);
      cneg_d = 1'b1;
    end else if (r <= 10'd270) begin
      sidx_d = 7'(r - 10'd180);
      cidx_d = 7'(10'd270 - r);
      sneg_d = 1'b1;
      cneg_d = 1'b1;
    end else begin
      sidx_d = 7'(10'd360 - r);
      cidx_d = 7'(r - 10'd270);
      sneg_d = 1'b1;
    end
  end

  assign adv          = !o_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_sidx  <= '0;
      s1_cidx  <= '0;
      s1_sneg  <= 1'b0;
      s1_cneg  <= 1'b0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_smag  <= '0;
      s2_cmag  <= '0;
      s2_sneg  <= 1'b0;
      s2_cneg  <= 1'b0;
      s2_tag   <= '0;
      o_valid  <= 1'b0;
      o_sin    <= '0;
      o_cos    <= '0;
      o_tag    <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sidx <= sidx_d;
        s1_cidx <= cidx_d;
        s1_sneg <= sneg_d;
        s1_cneg <= cneg_d;
        s1_tag  <= bus.in_tag;
      end
      s2_valid <= s1_valid;
      s2_smag  <= tbl[s1_sidx];
      s2_cmag  <= tbl[s1_cidx];
      s2_sneg  <= s1_sneg;
      s2_cneg  <= s1_cneg;
      s2_tag   <= s1_tag;
      o_valid  <= s2_valid;
      // Last result is kept on the outputs while bubbles pass.
      if (s2_valid) begin
        o_sin <= signed_out(s2_smag, s2_sneg);
        o_cos <= signed_out(s2_cmag, s2_cneg);
        o_tag <= s2_tag;
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.out_sin   = o_sin;
  assign bus.out_cos   = o_cos;
  assign bus.out_tag   = o_tag;

endmodule

// File: tb/tb_trig_lut_pipe.sv
// tb_trig_lut_pipe: self-checking bench for trig_lut_pipe.
// Main instance (ANGLE_W=9, FRAC_W=16) is checked through an expected-value
// queue filled on every accepted request from a $sin/$cos reference. Two extra
// instances cover ANGLE_W=10 and FRAC_W=12 with directed requests.
module tb_trig_lut_pipe;

  localparam real PI = 3.14159265358979323846;
  localparam int  W  = 4 + 18 + 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  trig_lut_pipe_if #(.ANGLE_W(9),  .TAG_W(4), .OUT_W(18)) m_if ();
  trig_lut_pipe_if #(.ANGLE_W(10), .TAG_W(4), .OUT_W(18)) w_if ();
  trig_lut_pipe_if #(.ANGLE_W(9),  .TAG_W(4), .OUT_W(14)) f_if ();

  trig_lut_pipe #(.ANGLE_W(9), .FRAC_W(16), .OUT_W(18), .TAG_W(4)) dut (
    .Clk(clk), .Reset(rst), .bus(m_if));
  trig_lut_pipe #(.ANGLE_W(10), .FRAC_W(16), .OUT_W(18), .TAG_W(4)) dut_w (
    .Clk(clk), .Reset(rst), .bus(w_if));
  trig_lut_pipe #(.ANGLE_W(9), .FRAC_W(12), .OUT_W(14), .TAG_W(4)) dut_f (
    .Clk(clk), .Reset(rst), .bus(f_if));

  // ---------------- reference model ----------------
  function automatic int ref_trig(input int a, input int fw, input bit want_cos);
    int  r;
    int  mag;
    real v;
    r   = (a >= 720) ? a - 720 : (a >= 360) ? a - 360 : a;
    v   = want_cos ? $cos(r * PI / 180.0) : $sin(r * PI / 180.0);
    mag = int'($floor(65536.0 * ((v < 0.0) ? -v : v) + 0.5));
    if (fw < 16) mag = (mag + (1 << (15 - fw))) >> (16 - fw);
    return (v < 0.0) ? -mag : mag;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  bit           lat_chk = 1'b0;
  bit           sweep_on = 1'b0;
  bit           count_acc = 1'b0;
  int           burst_acc = 0;
  int           sweep_n = 0;
  int           first_cyc = 0;
  int           last_cyc = 0;
  int           sweep_sin [0:359];
  int           last_sin = 0;
  int           last_cos = 0;
  int           last_tag = 0;
  bit           hold_valid = 1'b0;
  logic [W-1:0] hold_val;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (m_if.out_valid && !m_if.out_ready) begin
        if (hold_valid)
          check("stall_hold", {m_if.out_tag, m_if.out_sin, m_if.out_cos}, hold_val);
        hold_valid = 1'b1;
        hold_val   = {m_if.out_tag, m_if.out_sin, m_if.out_cos};
      end else begin
        hold_valid = 1'b0;
      end
      if (m_if.out_valid && m_if.out_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [W-1:0] e;
          int           ac;
          e  = exp_q.pop_front();
          ac = cyc_q.pop_front();
          check("out_tag", m_if.out_tag, e[39:36]);
          check("out_sin", m_if.out_sin, $signed(e[35:18]));
          check("out_cos", m_if.out_cos, $signed(e[17:0]));
          if (ac >= 0) check("latency", cyc - ac, 3);
          last_sin = m_if.out_sin;
          last_cos = m_if.out_cos;
          last_tag = int'(m_if.out_tag);
          if (sweep_on && sweep_n < 360) begin
            if (sweep_n == 0) first_cyc = cyc;
            last_cyc = cyc;
            sweep_sin[sweep_n] = m_if.out_sin;
            sweep_n++;
          end
        end
      end
      if (m_if.in_valid && m_if.in_ready) begin
        int s, c;
        s = ref_trig(int'(m_if.in_angle), 16, 1'b0);
        c = ref_trig(int'(m_if.in_angle), 16, 1'b1);
        exp_q.push_back({m_if.in_tag, 18'(s), 18'(c)});
        cyc_q.push_back(lat_chk ? cyc : -1);
        if (count_acc) burst_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge with
  // the request still presented so the caller can chain the next one.
  task automatic send(input int a, input int tag);
    int n;
    m_if.in_valid = 1'b1;
    m_if.in_angle = 9'(a);
    m_if.in_tag   = 4'(tag);
    n = 0;
    @(negedge clk);
    while (!m_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", m_if.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_w(input int a, output int s, output int c);
    int n;
    w_if.in_valid = 1'b1;
    w_if.in_angle = 10'(a);
    w_if.in_tag   = 4'(a);
    @(posedge clk);
    #1;
    w_if.in_valid = 1'b0;
    n = 0;
    while (!w_if.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w_valid", w_if.out_valid, 1);
    check("w_latency", n, 2);
    check("w_tag", w_if.out_tag, a & 15);
    s = w_if.out_sin;
    c = w_if.out_cos;
  endtask

  task automatic run_f(input int a, output int s, output int c);
    int n;
    f_if.in_valid = 1'b1;
    f_if.in_angle = 9'(a);
    f_if.in_tag   = 4'(a);
    @(posedge clk);
    #1;
    f_if.in_valid = 1'b0;
    n = 0;
    while (!f_if.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("f_valid", f_if.out_valid, 1);
    check("f_latency", n, 2);
    s = f_if.out_sin;
    c = f_if.out_cos;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s, c, s2, c2;
    m_if.in_valid = 1'b1;
    m_if.in_angle = 9'd45;
    m_if.in_tag   = 4'd9;
    m_if.out_ready = 1'b1;
    w_if.in_valid = 1'b0;
    w_if.in_angle = '0;
    w_if.in_tag   = '0;
    w_if.out_ready = 1'b1;
    f_if.in_valid = 1'b0;
    f_if.in_angle = '0;
    f_if.in_tag   = '0;
    f_if.out_ready = 1'b1;

    // reset held 2 cycles with a request presented
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", m_if.out_valid, 0);
    check("reset_out_sin", m_if.out_sin, 0);
    check("reset_out_cos", m_if.out_cos, 0);
    check("reset_out_tag", m_if.out_tag, 0);
    check("reset_in_ready", m_if.in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("reset_no_ghost", m_if.out_valid, 0);

    // single directed angles
    lat_chk = 1'b1;
    send(30, 3);
    m_if.in_valid = 1'b0;
    drain();
    check("a30_sin", last_sin, 32768);
    check("a30_cos", last_cos, 56756);
    check("a30_tag", last_tag, 3);
    send(270, 5);
    m_if.in_valid = 1'b0;
    drain();
    check("a270_sin", last_sin, -65536);
    check("a270_cos", last_cos, 0);
    send(180, 6);
    m_if.in_valid = 1'b0;
    drain();
    check("a180_sin", last_sin, 0);
    check("a180_cos", last_cos, -65536);

    // full-rate sweep 0..359
    sweep_n  = 0;
    sweep_on = 1'b1;
    for (int a = 0; a < 360; a++) send(a, a % 16);
    m_if.in_valid = 1'b0;
    drain();
    sweep_on = 1'b0;
    check("sweep_count", sweep_n, 360);
    check("sweep_back_to_back", last_cyc - first_cyc, 359);
    for (int a = 0; a < 180; a++)
      check("sweep_antisym", sweep_sin[a], -sweep_sin[a + 180]);

    // wide angle input and reduced fraction width
    run_w(400, s, c);
    check("w400_sin", s, 42126);
    check("w400_cos", c, 50203);
    run_w(40, s2, c2);
    check("w40_sin", s2, s);
    check("w40_cos", c2, c);
    run_w(303, s2, c2);
    check("w303_sin", s2, ref_trig(303, 16, 1'b0));
    check("w303_cos", c2, ref_trig(303, 16, 1'b1));
    run_w(1023, s, c);
    check("w1023_sin", s, s2);
    check("w1023_cos", c, c2);
    run_f(90, s, c);
    check("f90_sin", s, 4096);
    check("f90_cos", c, 0);
    run_f(200, s, c);
    check("f200_sin", s, ref_trig(200, 12, 1'b0));
    check("f200_cos", c, ref_trig(200, 12, 1'b1));

    // 8-request burst with a 6-cycle output stall
    lat_chk   = 1'b0;
    burst_acc = 0;
    count_acc = 1'b1;
    m_if.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom_range(0, 511), i);
        m_if.in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        check("burst_accepted", burst_acc, 3);
        check("stall_in_ready", m_if.in_ready, 0);
        @(posedge clk);
        #1;
        m_if.out_ready = 1'b1;
      end
    join
    drain();
    count_acc = 1'b0;
    check("burst_total", burst_acc, 8);
    check("burst_last_tag", last_tag, 7);

    // reset with requests in flight
    lat_chk = 1'b1;
    send(100, 1);
    send(200, 2);
    send(300, 3);
    rst = 1'b1;
    m_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", m_if.out_valid, 0);
    @(posedge clk);
    #1;
    send(45, 7);
    m_if.in_valid = 1'b0;
    drain();
    check("post_reset_tag", last_tag, 7);
    check("post_reset_sin", last_sin, 46341);

    repeat (4) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
